// File: rtl/display_dither_pkg.sv
// Shared tables for the 3-bit Pmod output stage: Bayer thresholds, per-frame
// pattern offsets and the pipeline pixel bundle.
package display_dither_pkg;

    typedef struct packed {
        logic [1:0] fx;
        logic [1:0] fy;
    } offset_t;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    // Indexed as {y, x}
    localparam logic [3:0] BAYER4 [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    localparam offset_t OFFSETS [4] = '{
        '{fx: 2'd0, fy: 2'd0},
        '{fx: 2'd2, fy: 2'd2},
        '{fx: 2'd2, fy: 2'd0},
        '{fx: 2'd0, fy: 2'd2}
    };

    // Centres each threshold inside its 16-code bucket
    localparam logic [3:0] T_LSB = 4'b1000;

    function automatic logic dither_lit(input logic [7:0] c, input logic [3:0] t);
        return c >= {t, T_LSB};
    endfunction

endpackage

// File: rtl/dither_threshold.sv
// Purpose: maps screen position low bits plus frame count to a 4-bit Bayer threshold.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module dither_threshold
    import display_dither_pkg::*;
#(
    parameter bit TEMPORAL = 1'b1
) (
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    input  logic [1:0] i_frame_cnt,
    output logic [3:0] o_t
);

    offset_t    w_off;
    logic [1:0] w_x;
    logic [1:0] w_y;

    always_comb begin
        w_off = '0;
        if (TEMPORAL) begin
            w_off = OFFSETS[i_frame_cnt];
        end
    end

    // 2-bit adds wrap mod 4, which is exactly the tile wrap
    assign w_x = i_x + w_off.fx;
    assign w_y = i_y + w_off.fy;
    assign o_t = BAYER4[{w_y, w_x}];

endmodule

// File: rtl/display_dither_pmod3.sv
// Purpose: 8-bit RGB to 1-bit-per-channel ordered dither driving the DVI Pmod pins.
// Latency: 2 cycles for colour, sync and enable alike.
// Backpressure: none; accepts one pixel every clock.
module display_dither_pmod3
    import display_dither_pkg::*;
#(
    parameter bit DITHER   = 1'b1,
    parameter bit TEMPORAL = 1'b1,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic        i_pix_clk,
    input  logic        i_rst,
    input  logic [15:0] i_sx,
    input  logic [15:0] i_sy,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic        i_frame,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic        o_red,
    output logic        o_green,
    output logic        o_blue
);

    localparam pix_t PIX_IDLE = '{hs: !H_POL, vs: !V_POL, de: 1'b0,
                                  r: 8'd0, g: 8'd0, b: 8'd0};

    logic [1:0] r_frame_cnt;
    pix_t       r_s1;
    logic [3:0] r_t;
    logic [3:0] w_t;
    logic       w_red;
    logic       w_green;
    logic       w_blue;
    logic       w_unused;

    // Only the tile position matters; the rest of the coordinate is ignored
    assign w_unused = ^{i_sx[15:2], i_sy[15:2]};

    dither_threshold #(
        .TEMPORAL (TEMPORAL && DITHER)
    ) u_thresh (
        .i_x         (i_sx[1:0]),
        .i_y         (i_sy[1:0]),
        .i_frame_cnt (r_frame_cnt),
        .o_t         (w_t)
    );

    always_comb begin
        w_red   = r_s1.r[7];
        w_green = r_s1.g[7];
        w_blue  = r_s1.b[7];
        if (DITHER) begin
            w_red   = dither_lit(r_s1.r, r_t);
            w_green = dither_lit(r_s1.g, r_t);
            w_blue  = dither_lit(r_s1.b, r_t);
        end
    end

    always_ff @(posedge i_pix_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_cnt <= 2'd0;
            r_s1        <= PIX_IDLE;
            r_t         <= 4'd0;
            o_hs        <= !H_POL;
            o_vs        <= !V_POL;
            o_de        <= 1'b0;
            o_red       <= 1'b0;
            o_green     <= 1'b0;
            o_blue      <= 1'b0;
        end else begin
            // Pixel sampled on the same edge as i_frame still sees the old count
            if (i_frame) begin
                r_frame_cnt <= r_frame_cnt + 2'd1;
            end
            r_s1    <= '{hs: i_hs, vs: i_vs, de: i_de, r: i_red, g: i_green, b: i_blue};
            r_t     <= w_t;
            o_hs    <= r_s1.hs;
            o_vs    <= r_s1.vs;
            o_de    <= r_s1.de;
            o_red   <= r_s1.de & w_red;
            o_green <= r_s1.de & w_green;
            o_blue  <= r_s1.de & w_blue;
        end
    end

endmodule
